// File: rtl/chunked_carry_adder_pkg.sv
// chunked_carry_adder_pkg: FSM state encoding and clog2 helper for the chunked adder
package chunked_carry_adder_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/chunked_carry_adder_fa_chunk.sv
// fa_chunk: combinational ripple of CHUNK full adders, also exposing the carry into the top bit
module fa_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_top
);
    logic [CHUNK:0] c;
    always_comb begin
        c[0] = ci;
        s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s[i] = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end
    assign co = c[CHUNK];
    assign c_top = c[CHUNK-1];
endmodule

// File: rtl/chunked_carry_adder.sv
// chunked_carry_adder: multi-cycle adder reusing one CHUNK-bit ripple slice through a registered carry
module chunked_carry_adder
    import chunked_carry_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW = clog2(NCH) < 1 ? 1 : clog2(NCH);
    if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunked_carry_adder: WIDTH must be a positive multiple of CHUNK");
    end
    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             c_top;
    fa_chunk #(.CHUNK(CHUNK)) u_fa (
        .x    (a_sh[CHUNK-1:0]),
        .y    (b_sh[CHUNK-1:0]),
        .ci   (carry_q),
        .s    (s),
        .co   (co),
        .c_top(c_top)
    );
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    // Chunk sums enter at the MSB end so the LSB chunk lands at bit 0 after NCH shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sum <= '0;
            cout <= 1'b0;
            ovf <= 1'b0;
            cnt <= '0;
            a_sh <= '0;
            b_sh <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh <= a;
                    b_sh <= b;
                    carry_q <= cin;
                    cnt <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum <= WIDTH'({s, sum} >> CHUNK);
                    a_sh <= a_sh >> CHUNK;
                    b_sh <= b_sh >> CHUNK;
                    carry_q <= co;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NCH - 1)) begin
                        cout <= co;
                        ovf <= c_top ^ co;
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chunked_carry_adder.sv
// tb_chunked_carry_adder: directed and random checks of three adder configurations against an arithmetic model
module tb_chunked_carry_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  iv, ordy, ir, ov, co, of;
    logic [15:0] a, b;
    logic        cin;
    logic [7:0]  s0, s1;
    logic [15:0] s2;
    logic [15:0] na, nb;
    logic        nc;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    chunked_carry_adder #(.WIDTH(8), .CHUNK(2)) d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .cout(co[0]), .ovf(of[0]));
    chunked_carry_adder #(.WIDTH(8), .CHUNK(8)) d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .cout(co[1]), .ovf(of[1]));
    chunked_carry_adder #(.WIDTH(16), .CHUNK(4)) d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b), .cin(cin),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2), .cout(co[2]), .ovf(of[2]));
    function automatic int wid(int i);
        return i == 2 ? 16 : 8;
    endfunction
    function automatic int nch(int i);
        return i == 1 ? 1 : 4;
    endfunction
    function automatic logic [15:0] get_sum(int i);
        return i == 0 ? {8'h00, s0} : i == 1 ? {8'h00, s1} : s2;
    endfunction
    // Returns {ovf, cout, sum[15:0]} from plain integer arithmetic.
    function automatic logic [17:0] model(int w, logic [15:0] x, logic [15:0] y, logic c);
        longint m, xa, ya, full, sx, sy, ss;
        logic [17:0] r;
        m = longint'(1) << w;
        xa = longint'(x) % m;
        ya = longint'(y) % m;
        full = xa + ya + longint'(c);
        sx = xa >= m / 2 ? xa - m : xa;
        sy = ya >= m / 2 ? ya - m : ya;
        ss = sx + sy + longint'(c);
        r[15:0] = 16'(full % m);
        r[16] = full >= m;
        r[17] = ss >= m / 2 || ss < -(m / 2);
        return r;
    endfunction
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic accept(int i, logic [15:0] x, logic [15:0] y, logic c);
        @(negedge clk);
        chk("in_ready_idle", 32'(ir[i]), 1);
        a = x;
        b = y;
        cin = c;
        iv[i] = 1'b1;
        @(negedge clk);
        iv[i] = 1'b0;
    endtask
    task automatic collect(int i, logic [15:0] x, logic [15:0] y, logic c, int stall, bit noise);
        logic [17:0] e;
        int lat;
        e = model(wid(i), x, y, c);
        lat = 0;
        while (!ov[i] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, nch(i));
        for (int k = 0; k < stall; k++) begin
            if (noise) begin
                a = 16'($urandom);
                b = 16'($urandom);
                cin = 1'($urandom);
                iv[i] = 1'b1;
                na = a;
                nb = b;
                nc = cin;
            end
            @(negedge clk);
            chk("stall_sum", 32'(get_sum(i)), 32'(e[15:0]));
            chk("stall_in_ready", 32'(ir[i]), 0);
        end
        chk("sum", 32'(get_sum(i)), 32'(e[15:0]));
        chk("cout", 32'(co[i]), 32'(e[16]));
        chk("ovf", 32'(of[i]), 32'(e[17]));
        chk("out_valid", 32'(ov[i]), 1);
        ordy[i] = 1'b1;
        @(negedge clk);
        ordy[i] = 1'b0;
        chk("idle_out_valid", 32'(ov[i]), 0);
        chk("idle_in_ready", 32'(ir[i]), 1);
    endtask
    logic [7:0] da [5] = '{8'hFF, 8'h7F, 8'h80, 8'h00, 8'hFF};
    logic [7:0] db [5] = '{8'h01, 8'h01, 8'h80, 8'h00, 8'hFF};
    logic       dc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    initial begin
        logic [15:0] x, y;
        logic c;
        rst = 1'b1;
        iv = '0;
        ordy = '0;
        a = '0;
        b = '0;
        cin = 1'b0;
        na = '0;
        nb = '0;
        nc = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(ov), 0);
        chk("rst_in_ready", 32'(ir), 32'h7);
        chk("rst_sum0", 32'(s0), 0);
        chk("rst_sum2", 32'(s2), 0);
        chk("rst_cout_ovf", 32'({co, of}), 0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            accept(0, {8'h00, da[k]}, {8'h00, db[k]}, dc[k]);
            collect(0, {8'h00, da[k]}, {8'h00, db[k]}, dc[k], 0, 1'b0);
        end
        accept(0, 16'h0055, 16'h002A, 1'b1);
        collect(0, 16'h0055, 16'h002A, 1'b1, 6, 1'b1);
        @(negedge clk);
        iv[0] = 1'b0;
        collect(0, na, nb, nc, 0, 1'b0);
        accept(0, 16'h00AA, 16'h0055, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(ov[0]), 0);
        chk("midrst_in_ready", 32'(ir[0]), 1);
        chk("midrst_sum", 32'(s0), 0);
        repeat (6) @(negedge clk);
        chk("midrst_no_result", 32'(ov[0]), 0);
        accept(0, 16'h0012, 16'h0034, 1'b0);
        collect(0, 16'h0012, 16'h0034, 1'b0, 0, 1'b0);
        chk("post_rst_sum_0x46", 32'(model(8, 16'h0012, 16'h0034, 1'b0)), 32'h46);
        for (int i = 1; i < 3; i++) begin
            repeat (1000) begin
                x = 16'($urandom) & (i == 2 ? 16'hFFFF : 16'h00FF);
                y = 16'($urandom) & (i == 2 ? 16'hFFFF : 16'h00FF);
                c = 1'($urandom);
                accept(i, x, y, c);
                collect(i, x, y, c, int'($urandom_range(0, 3)), 1'b0);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
